pit_8253: RTL and testbench

//  8253-compatible programmable interval timer at I/O 0x40-0x43, three 16-bit down-counters.
//  Ch0 out drives IRQ0 (timer) into the interrupt controller; ch1 is refresh (unused);
//  ch2 drives the speaker, gated by port 0x61 bit0. Counts on 1.193182 MHz enable pulses.

---
 rtl/pit_8253_pkg.sv | 55 +++++
 rtl/pit_8253_channel.sv | 219 +++++++++++++++++++++
 rtl/pit_8253.sv | 69 ++++++
 tb/tb_pit_8253.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pit_8253_pkg.sv
// Shared types and helpers for the 8253-compatible interval timer.
// Holds the mode/RW codes, port offsets and the reload arithmetic used by every channel.
package pit_8253_pkg;

  typedef enum logic [1:0] {
    M0 = 2'd0,
    M2 = 2'd2,
    M3 = 2'd3
  } pit_mode_t;

  typedef enum logic [1:0] {
    RW_LATCH = 2'b00,
    RW_LSB   = 2'b01,
    RW_MSB   = 2'b10,
    RW_WORD  = 2'b11
  } pit_rw_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2
  } ch_state_t;

  typedef struct packed {
    ch_state_t   state;
    logic        bcd;
    logic        latched;
    logic [15:0] count;
  } ch_dbg_t;

  localparam logic [1:0] ADDR_CH0  = 2'd0;
  localparam logic [1:0] ADDR_CH1  = 2'd1;
  localparam logic [1:0] ADDR_CH2  = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Modes 1/4/5 behave as mode 0, 6 as 2, 7 as 3.
  function automatic pit_mode_t decode_mode(input logic [2:0] m);
    pit_mode_t r;
    case (m)
      3'd2, 3'd6: r = M2;
      3'd3, 3'd7: r = M3;
      default:    r = M0;
    endcase
    return r;
  endfunction

  // A programmed 0 means 65536; periodic modes cannot run with a reload of 1.
  function automatic logic [16:0] eff_reload(input logic [15:0] r, input pit_mode_t md);
    logic [16:0] v;
    v = (r == 16'h0000) ? 17'h10000 : {1'b0, r};
    if ((md != M0) && (r == 16'h0001)) v = 17'd2;
    return v;
  endfunction

endpackage

// File: rtl/pit_8253_channel.sv
// One timer channel: reload register, IDLE/LOAD/COUNT sequencer, OUT, byte flops and
// the read-back latch. Counting advances only on tick.
module pit_8253_channel
  import pit_8253_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       gate,
  input  logic       ctrl_we,
  input  logic [5:0] ctrl_word,
  input  logic       data_we,
  input  logic       rd_stb,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       out_o,
  output ch_dbg_t    dbg_o
);

  ch_state_t   state_q, state_d;
  pit_mode_t   mode_q, mode_d;
  pit_rw_t     rw_q, rw_d;
  logic        bcd_q, bcd_d;
  logic [16:0] count_q, count_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  wr_lsb_q, wr_lsb_d;
  logic        wr_flop_q, wr_flop_d;
  logic        rd_flop_q, rd_flop_d;
  logic        latched_q, latched_d;
  logic [15:0] latch_q, latch_d;
  logic        out_q, out_d;
  logic        gate_prev_q, gate_prev_d;
  logic        trig_q, trig_d;

  logic [16:0] eff, half_hi, half_lo;
  logic        wr_done;
  logic [15:0] wr_value;
  logic [15:0] src;
  logic        rd_last;
  pit_mode_t   new_mode;

  always_comb begin
    eff      = eff_reload(reload_q, mode_q);
    half_hi  = (eff + 17'd1) >> 1;
    half_lo  = eff >> 1;
    new_mode = decode_mode(ctrl_word[3:1]);
  end

  always_comb begin
    wr_done  = 1'b0;
    wr_value = 16'h0000;
    case (rw_q)
      RW_LSB:  begin wr_done = 1'b1;      wr_value = {8'h00, wdata};    end
      RW_MSB:  begin wr_done = 1'b1;      wr_value = {wdata, 8'h00};    end
      RW_WORD: begin wr_done = wr_flop_q; wr_value = {wdata, wr_lsb_q}; end
      default: ;
    endcase
  end

  always_comb begin
    src     = latched_q ? latch_q : count_q[15:0];
    rd_last = (rw_q != RW_WORD) || rd_flop_q;
    case (rw_q)
      RW_MSB:  rdata = src[15:8];
      RW_WORD: rdata = rd_flop_q ? src[15:8] : src[7:0];
      default: rdata = src[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rw_d        = rw_q;
    bcd_d       = bcd_q;
    count_d     = count_q;
    reload_d    = reload_q;
    wr_lsb_d    = wr_lsb_q;
    wr_flop_d   = wr_flop_q;
    rd_flop_d   = rd_flop_q;
    latched_d   = latched_q;
    latch_d     = latch_q;
    out_d       = out_q;
    gate_prev_d = gate;
    trig_d      = trig_q;

    if (gate && !gate_prev_q && (state_q == ST_COUNT)) trig_d = 1'b1;

    if (tick) begin
      case (state_q)
        ST_LOAD: begin
          count_d = (mode_q == M3) ? half_hi : eff;
          out_d   = (mode_q != M0);
          trig_d  = 1'b0;
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (gate) begin
            case (mode_q)
              M2: begin
                if (trig_q || (count_q == 17'd1)) begin
                  count_d = eff;
                  out_d   = 1'b1;
                  trig_d  = 1'b0;
                end else begin
                  count_d = count_q - 17'd1;
                  out_d   = (count_q != 17'd2);
                end
              end
              M3: begin
                // OUT doubles as the phase flag: high phase reloads ceil, low phase floor.
                if (trig_q) begin
                  count_d = half_hi;
                  out_d   = 1'b1;
                  trig_d  = 1'b0;
                end else if (count_q == 17'd1) begin
                  count_d = out_q ? half_lo : half_hi;
                  out_d   = !out_q;
                end else begin
                  count_d = count_q - 17'd1;
                end
              end
              default: begin
                count_d = (count_q == 17'd0) ? 17'h0FFFF : count_q - 17'd1;
                if (count_q == 17'd1) out_d = 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end

    if ((mode_q != M0) && !gate) out_d = 1'b1;

    if (data_we && (rw_q != RW_LATCH)) begin
      if (rw_q == RW_WORD) begin
        wr_flop_d = !wr_flop_q;
        if (!wr_flop_q) wr_lsb_d = wdata;
      end
      if (mode_q == M0) begin
        out_d   = 1'b0;
        state_d = wr_done ? ST_LOAD : ST_IDLE;
      end else if (wr_done && (state_q != ST_COUNT)) begin
        state_d = ST_LOAD;
      end
      if (wr_done) reload_d = wr_value;
    end

    if (rd_stb) begin
      if (rw_q == RW_WORD) rd_flop_d = !rd_flop_q;
      if (latched_q && rd_last) latched_d = 1'b0;
    end

    // Control writes take priority over a coincident tick: the count is frozen this cycle.
    if (ctrl_we) begin
      if (ctrl_word[5:4] == RW_LATCH) begin
        if (!latched_q) begin
          latched_d = 1'b1;
          latch_d   = count_q[15:0];
        end
      end else begin
        rw_d      = pit_rw_t'(ctrl_word[5:4]);
        mode_d    = new_mode;
        bcd_d     = ctrl_word[0];
        wr_flop_d = 1'b0;
        rd_flop_d = 1'b0;
        latched_d = 1'b0;
        trig_d    = 1'b0;
        count_d   = count_q;
        state_d   = ST_IDLE;
        out_d     = (new_mode != M0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= M0;
      rw_q        <= RW_LATCH;
      bcd_q       <= 1'b0;
      count_q     <= 17'd0;
      reload_q    <= 16'd0;
      wr_lsb_q    <= 8'd0;
      wr_flop_q   <= 1'b0;
      rd_flop_q   <= 1'b0;
      latched_q   <= 1'b0;
      latch_q     <= 16'd0;
      out_q       <= 1'b0;
      gate_prev_q <= 1'b0;
      trig_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rw_q        <= rw_d;
      bcd_q       <= bcd_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      wr_lsb_q    <= wr_lsb_d;
      wr_flop_q   <= wr_flop_d;
      rd_flop_q   <= rd_flop_d;
      latched_q   <= latched_d;
      latch_q     <= latch_d;
      out_q       <= out_d;
      gate_prev_q <= gate_prev_d;
      trig_q      <= trig_d;
    end
  end

  assign out_o = out_q;

  always_comb begin
    dbg_o.state   = state_q;
    dbg_o.bcd     = bcd_q;
    dbg_o.latched = latched_q;
    dbg_o.count   = count_q[15:0];
  end

endmodule

// File: rtl/pit_8253.sv
// 8253-compatible interval timer: decodes ports 0x40-0x43 onto three channels and muxes
// read data. Ch0 drives IRQ0, ch2 is gated by iGate2 for the speaker.
module pit_8253
  import pit_8253_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTick,
  input  logic       iSel,
  input  logic [1:0] iAddr,
  input  logic       iWr,
  input  logic       iRd,
  input  logic [7:0] iData,
  output logic [7:0] oData,
  input  logic       iGate2,
  output logic       oIrq0,
  output logic       oOut1,
  output logic       oOut2
);

  // iWr/iRd are single-cycle strobes qualified by iSel; there is no back-pressure, every
  // strobe is accepted on the clock edge it is high, and oData is valid while iSel&iRd.
  logic [2:0] ctrl_we, data_we, rd_stb, gate, out;
  logic [7:0] rdata [3];
  ch_dbg_t    dbg [3];
  logic       unused_dbg;

  assign gate = {iGate2, 1'b1, 1'b1};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    assign data_we[g] = iSel && iWr && (iAddr == 2'(g));
    assign rd_stb[g]  = iSel && iRd && (iAddr == 2'(g));
    assign ctrl_we[g] = iSel && iWr && (iAddr == ADDR_CTRL) && (iData[7:6] == 2'(g));

    pit_8253_channel u_ch (
      .clk       (iClk),
      .rst       (iRst),
      .tick      (iTick),
      .gate      (gate[g]),
      .ctrl_we   (ctrl_we[g]),
      .ctrl_word (iData[5:0]),
      .data_we   (data_we[g]),
      .rd_stb    (rd_stb[g]),
      .wdata     (iData),
      .rdata     (rdata[g]),
      .out_o     (out[g]),
      .dbg_o     (dbg[g])
    );
  end

  always_comb begin
    oData = 8'hFF;
    if (iSel && iRd) begin
      case (iAddr)
        ADDR_CH0: oData = rdata[0];
        ADDR_CH1: oData = rdata[1];
        ADDR_CH2: oData = rdata[2];
        default:  oData = 8'hFF;
      endcase
    end
  end

  assign oIrq0 = out[0];
  assign oOut1 = out[1];
  assign oOut2 = out[2];

  assign unused_dbg = ^{dbg[0], dbg[1], dbg[2]};

endmodule

// File: tb/tb_pit_8253.sv
// Directed bench for pit_8253: expected values are queued as stimulus is applied and
// popped when the corresponding output is sampled on the falling clock edge.
module tb_pit_8253;

  logic       iClk = 1'b0;
  logic       iRst, iTick, iSel, iWr, iRd, iGate2;
  logic [1:0] iAddr;
  logic [7:0] iData;
  logic [7:0] oData;
  logic       oIrq0, oOut1, oOut2;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  rd_val;

  pit_8253 dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iTick  (iTick),
    .iSel   (iSel),
    .iAddr  (iAddr),
    .iWr    (iWr),
    .iRd    (iRd),
    .iData  (iData),
    .oData  (oData),
    .iGate2 (iGate2),
    .oIrq0  (oIrq0),
    .oOut1  (oOut1),
    .oOut2  (oOut2)
  );

  always #5 iClk = ~iClk;

  task automatic ticks(input int n);
    @(negedge iClk);
    iTick = 1'b1;
    repeat (n) @(negedge iClk);
    iTick = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge iClk);
    iSel = 1'b1; iWr = 1'b1; iAddr = a; iData = d;
    @(negedge iClk);
    iSel = 1'b0; iWr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge iClk);
    iSel = 1'b1; iRd = 1'b1; iAddr = a;
    #1 d = oData;
    @(negedge iClk);
    iSel = 1'b0; iRd = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: got %h, expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  function automatic logic m3_out(input int k, input int n);
    return ((k % n) < ((n + 1) / 2));
  endfunction

  function automatic logic m2_out(input int k, input int n);
    return ((k % n) != (n - 1));
  endfunction

  initial begin
    iRst = 1'b1; iTick = 1'b0; iSel = 1'b0; iWr = 1'b0; iRd = 1'b0;
    iGate2 = 1'b1; iAddr = 2'd0; iData = 8'h00;
    repeat (3) @(negedge iClk);
    iRst = 1'b0;

    // reset state
    push(16'h0); check("rst_irq0", {15'b0, oIrq0});
    push(16'h0); check("rst_out1", {15'b0, oOut1});
    push(16'h0); check("rst_out2", {15'b0, oOut2});
    push(16'h00FF); check("rst_odata_idle", {8'h00, oData});
    bus_rd(2'd3, rd_val);
    push(16'h00FF); check("rd_ctrl_port", {8'h00, rd_val});
    ticks(3);
    push(16'h0); check("idle_irq0", {15'b0, oIrq0});
    push(16'h0); check("idle_out2", {15'b0, oOut2});

    // ch0 mode 3, count 4
    bus_wr(2'd3, 8'h36);
    push(16'h1); check("m3_ctrl_out", {15'b0, oIrq0});
    bus_wr(2'd0, 8'h04);
    bus_wr(2'd0, 8'h00);
    for (int k = 0; k < 12; k++) begin
      push({15'b0, m3_out(k, 4)});
      ticks(1);
      check("m3_n4", {15'b0, oIrq0});
    end

    // ch0 mode 3, count 5
    bus_wr(2'd3, 8'h36);
    bus_wr(2'd0, 8'h05);
    bus_wr(2'd0, 8'h00);
    for (int k = 0; k < 15; k++) begin
      push({15'b0, m3_out(k, 5)});
      ticks(1);
      check("m3_n5", {15'b0, oIrq0});
    end

    // ch0 mode 3, count 0 = 65536: 32768 high, 32768 low
    bus_wr(2'd3, 8'h36);
    bus_wr(2'd0, 8'h00);
    bus_wr(2'd0, 8'h00);
    ticks(1);
    push(16'h1); check("m3_n0_load", {15'b0, oIrq0});
    ticks(32767);
    push(16'h1); check("m3_n0_high_end", {15'b0, oIrq0});
    ticks(1);
    push(16'h0); check("m3_n0_low_start", {15'b0, oIrq0});
    ticks(32767);
    push(16'h0); check("m3_n0_low_end", {15'b0, oIrq0});
    ticks(1);
    push(16'h1); check("m3_n0_high_again", {15'b0, oIrq0});

    // ch2 mode 2, count 3, gate behaviour
    bus_wr(2'd3, 8'hB4);
    push(16'h1); check("m2_ctrl_out", {15'b0, oOut2});
    bus_wr(2'd2, 8'h03);
    bus_wr(2'd2, 8'h00);
    for (int k = 0; k < 9; k++) begin
      push({15'b0, m2_out(k, 3)});
      ticks(1);
      check("m2_n3", {15'b0, oOut2});
    end
    iGate2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(16'h1);
      ticks(1);
      check("m2_gate_low", {15'b0, oOut2});
    end
    iGate2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push({15'b0, m2_out(k, 3)});
      ticks(1);
      check("m2_gate_rise", {15'b0, oOut2});
    end
    iGate2 = 1'b0;

    // ch0 latch while counting: half count 0x91A after load
    bus_wr(2'd3, 8'h36);
    bus_wr(2'd0, 8'h34);
    bus_wr(2'd0, 8'h12);
    ticks(1);
    ticks(5);
    bus_wr(2'd3, 8'h00);
    ticks(3);
    push(16'h0015); bus_rd(2'd0, rd_val); check("latch_lsb", {8'h00, rd_val});
    ticks(1);
    push(16'h0009); bus_rd(2'd0, rd_val); check("latch_msb", {8'h00, rd_val});
    push(16'h0011); bus_rd(2'd0, rd_val); check("live_lsb", {8'h00, rd_val});
    push(16'h0009); bus_rd(2'd0, rd_val); check("live_msb", {8'h00, rd_val});

    // ch1 mode 0, LSB only, count 5
    bus_wr(2'd3, 8'h54);
    push(16'h1); check("m2_ctrl_out1", {15'b0, oOut1});
    bus_wr(2'd3, 8'h50);
    push(16'h0); check("m0_ctrl_out1", {15'b0, oOut1});
    bus_wr(2'd1, 8'h05);
    ticks(1);
    push(16'h0); check("m0_load_out", {15'b0, oOut1});
    push(16'h0005); bus_rd(2'd1, rd_val); check("m0_load_cnt", {8'h00, rd_val});
    for (int k = 1; k <= 5; k++) begin
      push((k >= 5) ? 16'h1 : 16'h0);
      ticks(1);
      check("m0_count", {15'b0, oOut1});
    end
    push(16'h0000); bus_rd(2'd1, rd_val); check("m0_zero", {8'h00, rd_val});
    ticks(1);
    push(16'h1); check("m0_stay_high", {15'b0, oOut1});
    push(16'h00FF); bus_rd(2'd1, rd_val); check("m0_wrap", {8'h00, rd_val});
    ticks(3);
    push(16'h00FC); bus_rd(2'd1, rd_val); check("m0_after_wrap", {8'h00, rd_val});

    // asynchronous reset mid-count
    push(16'h1); check("pre_rst_irq0", {15'b0, oIrq0});
    push(16'h1); check("pre_rst_out1", {15'b0, oOut1});
    push(16'h1); check("pre_rst_out2", {15'b0, oOut2});
    @(negedge iClk);
    #2 iRst = 1'b1;
    #1;
    push(16'h0); check("async_rst_irq0", {15'b0, oIrq0});
    push(16'h0); check("async_rst_out1", {15'b0, oOut1});
    push(16'h0); check("async_rst_out2", {15'b0, oOut2});
    push(16'h00FF); check("async_rst_odata", {8'h00, oData});
    @(negedge iClk);
    iRst = 1'b0;
    iGate2 = 1'b1;
    ticks(4);
    push(16'h0); check("post_rst_irq0", {15'b0, oIrq0});
    push(16'h0); check("post_rst_out1", {15'b0, oOut1});
    push(16'h0); check("post_rst_out2", {15'b0, oOut2});

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
